uart_ctrl: RTL and testbench

//   Bus-master sequencer for the memory-mapped uart peripheral. Programs the clock divider once

---
 rtl/uart_ctrl.sv | 170 +++++++++++++++++
 tb/tb_uart_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl.sv
// Bus-master sequencer for the memory-mapped uart: programs CLK_DIV once, then round-robin
// arbitrates NUM_REQ TX requesters. Optional RX drain path under `UART_CTRL_RX_EN.
module uart_ctrl #(
  parameter int          NUM_REQ   = 4,
  parameter logic [15:0] CLK_DIV   = 16'd207,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid_in,
  input  logic [8*NUM_REQ-1:0] req_data_in,
  output logic [NUM_REQ-1:0]   req_ready_out,
  output logic                 rx_valid_out,
  output logic [7:0]           rx_data_out,
  input  logic                 rx_ready_in,
  output logic                 uart_sel_out,
  output logic                 uart_read_out,
  output logic [3:0]           uart_write_mask_out,
  output logic [31:0]          uart_address_out,
  output logic [31:0]          uart_write_value_out,
  input  logic [31:0]          uart_read_value_in
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [GW-1:0] RR_INIT = GW'(NUM_REQ - 1);

  localparam logic [31:0] ADDR_DIV    = BASE_ADDR;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_DATA   = BASE_ADDR + 32'h8;

  typedef enum logic [1:0] {
    S_INIT,
    S_POLL,
    S_TX_WRITE,
    S_RX_READ
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant, grant_nxt;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   pick;
  logic            pick_found;
  logic [1:0]      st;
  logic            rx_take;
  logic [7:0]      tx_byte;

  logic            bus_sel;
  logic            bus_read;
  logic [3:0]      bus_mask;
  logic [31:0]     bus_addr;
  logic [31:0]     bus_wdata;
  logic [NUM_REQ-1:0] ready_vec;

  assign st      = uart_read_value_in[1:0];
  assign tx_byte = req_data_in[{grant, 3'b000} +: 8];

  // Round-robin: first valid requester strictly after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = rr_ptr;
    pick_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found && req_valid_in[idx[GW-1:0]]) begin
        pick_found = 1'b1;
        pick       = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    bus_sel   = 1'b0;
    bus_read  = 1'b0;
    bus_mask  = 4'b0000;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    ready_vec = '0;
    case (state)
      S_INIT: begin
        bus_sel   = 1'b1;
        bus_addr  = ADDR_DIV;
        bus_mask  = 4'b0011;
        bus_wdata = {16'b0, CLK_DIV};
        state_nxt = S_POLL;
      end
      S_POLL: begin
        bus_sel  = 1'b1;
        bus_read = 1'b1;
        bus_addr = ADDR_STATUS;
        if (rx_take) begin
          state_nxt = S_RX_READ;
        end else if (st[0] && pick_found) begin
          grant_nxt = pick;
          state_nxt = S_TX_WRITE;
        end
      end
      S_TX_WRITE: begin
        bus_sel          = 1'b1;
        bus_addr         = ADDR_DATA;
        bus_mask         = 4'b0001;
        bus_wdata        = {24'b0, tx_byte};
        ready_vec[grant] = 1'b1;
        state_nxt        = S_POLL;
      end
      S_RX_READ: begin
        bus_sel   = 1'b1;
        bus_read  = 1'b1;
        bus_addr  = ADDR_DATA;
        state_nxt = S_POLL;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_INIT;
      grant  <= '0;
      rr_ptr <= RR_INIT;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (state == S_TX_WRITE) rr_ptr <= grant;
    end
  end

  // Reset forces the Moore bus outputs low immediately, aborting any access in flight.
  assign uart_sel_out         = bus_sel & ~reset;
  assign uart_read_out        = bus_read & ~reset;
  assign uart_write_mask_out  = reset ? 4'b0000 : bus_mask;
  assign uart_address_out     = reset ? 32'h0 : bus_addr;
  assign uart_write_value_out = reset ? 32'h0 : bus_wdata;
  assign req_ready_out        = reset ? '0 : ready_vec;

`ifdef UART_CTRL_RX_EN
  logic       rx_valid_q;
  logic [7:0] rx_data_q;
  logic [23:0] unused_rd_hi;

  assign rx_take      = st[1] && !rx_valid_q;
  assign unused_rd_hi = uart_read_value_in[31:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else if (state == S_RX_READ) begin
      rx_valid_q <= 1'b1;
      rx_data_q  <= uart_read_value_in[7:0];
    end else if (rx_ready_in && rx_valid_q) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign rx_valid_out = rx_valid_q;
  assign rx_data_out  = rx_data_q;
`else
  logic unused_rx;

  assign rx_take      = 1'b0;
  assign unused_rx    = ^{rx_ready_in, uart_read_value_in[31:2]};
  assign rx_valid_out = 1'b0;
  assign rx_data_out  = 8'h00;
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl with a small behavioural uart register model.
module tb_uart_ctrl;
  localparam int          NR   = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          BUSY = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NR-1:0] req_valid_in = '0;
  logic [8*NR-1:0] req_data_in = '0;
  logic [NR-1:0] req_ready_out;
  logic          rx_valid_out;
  logic [7:0]    rx_data_out;
  logic          rx_ready_in = 1'b0;
  logic          uart_sel_out;
  logic          uart_read_out;
  logic [3:0]    uart_write_mask_out;
  logic [31:0]   uart_address_out;
  logic [31:0]   uart_write_value_out;
  logic [31:0]   uart_read_value_in;

  uart_ctrl #(.NUM_REQ(NR), .CLK_DIV(16'd4), .BASE_ADDR(BASE)) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid_in         (req_valid_in),
    .req_data_in          (req_data_in),
    .req_ready_out        (req_ready_out),
    .rx_valid_out         (rx_valid_out),
    .rx_data_out          (rx_data_out),
    .rx_ready_in          (rx_ready_in),
    .uart_sel_out         (uart_sel_out),
    .uart_read_out        (uart_read_out),
    .uart_write_mask_out  (uart_write_mask_out),
    .uart_address_out     (uart_address_out),
    .uart_write_value_out (uart_write_value_out),
    .uart_read_value_in   (uart_read_value_in)
  );

  always #5 clk = ~clk;

  // Behavioural uart registers: TX busy for BUSY clocks after a DATA write, RX byte latch.
  int          busy_cnt = 0;
  int          rx_load_cnt = 0;
  int          rx_read_cnt = 0;
  logic [7:0]  rx_byte = 8'h00;
  logic [15:0] model_div = 16'h0;
  logic        tx_ready, rx_avail;

  assign tx_ready = (busy_cnt == 0);
  assign rx_avail = (rx_load_cnt != rx_read_cnt);
  assign uart_read_value_in = (uart_address_out == BASE + 32'h4) ? {30'b0, rx_avail, tx_ready} :
                              (uart_address_out == BASE + 32'h8) ? {24'b0, rx_byte} : 32'h0;

  always @(posedge clk) begin
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (uart_sel_out && uart_write_mask_out != 4'b0 && uart_address_out == BASE + 32'h8)
      busy_cnt <= BUSY;
    if (uart_sel_out && uart_write_mask_out != 4'b0 && uart_address_out == BASE)
      model_div <= uart_write_value_out[15:0];
    if (uart_sel_out && uart_read_out && uart_address_out == BASE + 32'h8)
      rx_read_cnt <= rx_read_cnt + 1;
  end

  typedef struct {
    bit          is_rx;
    logic [71:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails = 0;

  task automatic check(input string nm, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_w(input string nm, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, input logic [3:0] r);
    exp_t e;
    e.is_rx = 1'b0;
    e.val   = {a, m, d, r};
    e.name  = nm;
    q.push_back(e);
  endtask

  task automatic push_r(input string nm, input logic [7:0] b);
    exp_t e;
    e.is_rx = 1'b1;
    e.val   = {64'b0, b};
    e.name  = nm;
    q.push_back(e);
  endtask

  // Monitor: every bus write and every rx_valid rise consumes the next expected event.
  initial begin
    exp_t e;
    logic prev_rx;
    prev_rx = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (uart_sel_out && uart_write_mask_out != 4'b0) begin
          if (q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_write: got addr %h data %h ready %b expected none",
                     uart_address_out, uart_write_value_out, req_ready_out);
          end else begin
            e = q.pop_front();
            check(e.name, {1'b0, uart_address_out, uart_write_mask_out, uart_write_value_out,
                  req_ready_out}, {e.is_rx, e.val});
          end
        end
        if (rx_valid_out && !prev_rx) begin
          if (q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_rx: got %h expected none", rx_data_out);
          end else begin
            e = q.pop_front();
            check(e.name, {1'b1, 64'b0, rx_data_out}, {e.is_rx, e.val});
          end
        end
        if (req_ready_out != '0 && !(uart_sel_out && uart_write_mask_out != 4'b0)) begin
          checks++; fails++;
          $display("FAIL stray_ready: got %b expected 0", req_ready_out);
        end
`ifndef UART_CTRL_RX_EN
        if (uart_sel_out && uart_read_out && uart_address_out == BASE + 32'h8) begin
          checks++; fails++;
          $display("FAIL data_read: got read of DATA expected none");
        end
`endif
      end
      prev_rx = rx_valid_out;
    end
  end

  task automatic wait_pulses(input string nm, input int n, input int budget);
    int seen, cyc;
    seen = 0; cyc = 0;
    while (seen < n && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (req_ready_out != '0) seen++;
    end
    if (seen < n) check({nm, "_timeout"}, 73'(seen), 73'(n));
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int cyc;
    cyc = 0;
    while ((q.size() != 0 || busy_cnt != 0) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (q.size() != 0) check({nm, "_idle_timeout"}, 73'(q.size()), 73'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string nm);
    check(nm, 73'({uart_sel_out, uart_read_out, uart_write_mask_out, uart_address_out,
                   uart_write_value_out, req_ready_out, rx_valid_out, rx_data_out}), 73'(0));
  endtask

  initial begin
    // Reset state, then CLK_DIV programming
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_outputs");
    push_w("init_div", BASE, 4'b0011, 32'd4, 4'b0000);
    reset = 1'b0;
    wait_idle("init", 50);
    check("clk_div_reg", 73'(model_div), 73'(16'd4));

    // Single requester, one write per byte
    req_data_in[7:0] = 8'h55;
    push_w("tx_55", BASE + 32'h8, 4'b0001, 32'h55, 4'b0001);
    req_valid_in = 4'b0001;
    wait_pulses("tx_55", 1, 50);
    req_valid_in = 4'b0000;
    wait_idle("tx_55", 80);

    // Fresh reset: all requesters valid -> 0,1,2,3,0
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    push_w("init_div2", BASE, 4'b0011, 32'd4, 4'b0000);
    req_data_in = 32'hA3A2_A1A0;
    push_w("rr_g0", BASE + 32'h8, 4'b0001, 32'hA0, 4'b0001);
    push_w("rr_g1", BASE + 32'h8, 4'b0001, 32'hA1, 4'b0010);
    push_w("rr_g2", BASE + 32'h8, 4'b0001, 32'hA2, 4'b0100);
    push_w("rr_g3", BASE + 32'h8, 4'b0001, 32'hA3, 4'b1000);
    push_w("rr_g0b", BASE + 32'h8, 4'b0001, 32'hA0, 4'b0001);
    req_valid_in = 4'b1111;
    wait_pulses("rr_all", 5, 200);
    req_valid_in = 4'b0000;
    wait_idle("rr_all", 80);

    // Sparse requesters with wrap: rr=0 -> 1,3,1
    push_w("sp_g1", BASE + 32'h8, 4'b0001, 32'hA1, 4'b0010);
    push_w("sp_g3", BASE + 32'h8, 4'b0001, 32'hA3, 4'b1000);
    push_w("sp_g1b", BASE + 32'h8, 4'b0001, 32'hA1, 4'b0010);
    req_valid_in = 4'b1010;
    wait_pulses("sparse", 3, 150);
    req_valid_in = 4'b0000;
    wait_idle("sparse", 80);

`ifdef UART_CTRL_RX_EN
    // RX drain and hold while unconsumed
    rx_byte = 8'h3C;
    push_r("rx_3c", 8'h3C);
    rx_load_cnt++;
    wait_idle("rx_3c", 50);
    rx_byte = 8'h3D;
    rx_load_cnt++;
    repeat (30) @(posedge clk);
    #1;
    check("rx_hold_data", 73'(rx_data_out), 73'(8'h3C));
    check("rx_hold_valid", 73'(rx_valid_out), 73'(1));
    check("rx_hold_pending", 73'(rx_avail), 73'(1));
    push_r("rx_3d", 8'h3D);
    rx_ready_in = 1'b1;
    @(posedge clk); #1;
    rx_ready_in = 1'b0;
    wait_idle("rx_3d", 50);
    rx_ready_in = 1'b1;
    @(posedge clk); #1;
    rx_ready_in = 1'b0;
    check("rx_consumed", 73'(rx_valid_out), 73'(0));

    // RX and TX ready in the same POLL: RX first (rr=1 -> grant 2)
    rx_byte = 8'h5A;
    push_r("prio_rx", 8'h5A);
    push_w("prio_tx", BASE + 32'h8, 4'b0001, 32'hA2, 4'b0100);
    rx_load_cnt++;
    req_valid_in = 4'b0100;
    wait_pulses("prio", 1, 50);
    req_valid_in = 4'b0000;
    wait_idle("prio", 80);
    rx_ready_in = 1'b1;
    @(posedge clk); #1;
    rx_ready_in = 1'b0;
    check("prio_consumed", 73'(rx_valid_out), 73'(0));
`else
    // RX disabled: pending RX byte is ignored and never read
    rx_byte = 8'h3C;
    rx_load_cnt++;
    push_w("norx_tx", BASE + 32'h8, 4'b0001, 32'hA2, 4'b0100);
    req_valid_in = 4'b0100;
    rx_ready_in = 1'b1;
    wait_pulses("norx", 1, 50);
    req_valid_in = 4'b0000;
    wait_idle("norx", 80);
    rx_ready_in = 1'b0;
    check("norx_valid", 73'(rx_valid_out), 73'(0));
    check("norx_data", 73'(rx_data_out), 73'(0));
    check("norx_pending", 73'(rx_avail), 73'(1));
`endif

    // Reset asserted during TX_WRITE: outputs drop at once, INIT follows release
    begin
      int cyc;
      req_data_in[7:0] = 8'h77;
      push_w("tx_77", BASE + 32'h8, 4'b0001, 32'h77, 4'b0001);
      req_valid_in = 4'b0001;
      cyc = 0;
      while (req_ready_out == '0 && cyc < 50) begin
        @(negedge clk); #1;
        cyc++;
      end
      check("tx_77_seen", 73'(req_ready_out), 73'(4'b0001));
      reset = 1'b1;
      req_valid_in = 4'b0000;
      #1;
      check_outputs_zero("reset_async");
      push_w("init_div3", BASE, 4'b0011, 32'd4, 4'b0000);
      @(posedge clk); #1;
      reset = 1'b0;
      wait_idle("post_reset", 50);
      repeat (20) @(posedge clk);
      #1;
      check("queue_drained", 73'(q.size()), 73'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
